// File: rtl/dbg_bus_if.sv
// Signal bundle between the debug bus master and its UART / RAM-bus neighbours.
// Handshakes: rx_vld and tx_vld are one-cycle strobes with no back-pressure; tx_vld
// only rises while txrdy is high. bus_req stays high until the grant is used, and
// ram_rdata is valid the cycle after the ram_cen cycle.
interface dbg_bus_if;
  logic        rx_vld;
  logic [7:0]  rx_data;
  logic        txrdy;
  logic        tx_vld;
  logic [7:0]  tx_data;
  logic        bus_req;
  logic        bus_gnt;
  logic        ram_cen;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [3:0]  ram_flag;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        busy;

  modport master (
    input  rx_vld, rx_data, txrdy, bus_gnt, ram_rdata,
    output tx_vld, tx_data, bus_req, ram_cen, ram_wen, ram_addr, ram_flag, ram_wdata, busy
  );

  modport slave (
    output rx_vld, rx_data, txrdy, bus_gnt, ram_rdata,
    input  tx_vld, tx_data, bus_req, ram_cen, ram_wen, ram_addr, ram_flag, ram_wdata, busy
  );
endinterface

// File: rtl/dbg_bus_master.sv
// UART-driven debug master: decodes 'W'/'R' packets into single-word bus
// accesses and reports the result ('K', read data, or '?') back over the UART.
module dbg_bus_master #(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        rst,
  dbg_bus_if.master   bus,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_REQ, S_ACC, S_RDWAIT, S_RESP
  } state_t;

  localparam logic [7:0]  CMD_W    = 8'h57;
  localparam logic [7:0]  CMD_R    = 8'h52;
  localparam logic [7:0]  RSP_ERR  = 8'h3F;
  localparam logic [7:0]  RSP_OK   = 8'h4B;
  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cmd_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [1:0]  byte_cnt_q;
  logic [2:0]  resp_cnt_q;
  logic [19:0] tmo_cnt_q;
  logic        tx_vld_q;

  logic is_write;
  logic cmd_ok;
  logic tmo_hit;
  logic tx_fire;

  assign is_write = (cmd_q == CMD_W);
  assign cmd_ok   = (bus.rx_data == CMD_W) || (bus.rx_data == CMD_R);
  assign tmo_hit  = (tmo_cnt_q == TMO_LAST);
  // A byte goes out only on txrdy and never back-to-back.
  assign tx_fire  = (state_q == S_RESP) && bus.txrdy && !tx_vld_q;
  assign state_o  = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.rx_vld) state_d = cmd_ok ? S_ADDR : S_RESP;
      S_ADDR: begin
        if (bus.rx_vld) begin
          if (byte_cnt_q == 2'd3) state_d = is_write ? S_DATA : S_REQ;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (bus.rx_vld) begin
          if (byte_cnt_q == 2'd3) state_d = S_REQ;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
        end
      end
      S_REQ:    if (bus.bus_gnt) state_d = S_ACC;
      S_ACC:    state_d = is_write ? S_RESP : S_RDWAIT;
      S_RDWAIT: state_d = S_RESP;
      S_RESP:   if (tx_fire && (resp_cnt_q == 3'd1)) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.bus_req   = (state_q == S_REQ) || (state_q == S_ACC);
    bus.ram_cen   = (state_q == S_ACC);
    bus.ram_wen   = (state_q == S_ACC) && is_write;
    bus.ram_addr  = {addr_q[31:2], 2'b00};
    bus.ram_flag  = 4'hF;
    bus.ram_wdata = wdata_q;
    bus.tx_vld    = tx_fire;
    bus.tx_data   = rdata_q[31:24];
    bus.busy      = (state_q != S_IDLE);
  end

  // rdata_q doubles as the response shift register, MSB byte on tx_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      byte_cnt_q <= '0;
      resp_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      tx_vld_q   <= 1'b0;
    end else begin
      tx_vld_q <= tx_fire;
      case (state_q)
        S_IDLE: begin
          if (bus.rx_vld) begin
            cmd_q      <= bus.rx_data;
            byte_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            if (!cmd_ok) begin
              rdata_q    <= {RSP_ERR, 24'h0};
              resp_cnt_q <= 3'd1;
            end
          end
        end
        S_ADDR: begin
          if (bus.rx_vld) begin
            addr_q     <= {addr_q[23:0], bus.rx_data};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            tmo_cnt_q  <= '0;
          end else begin
            tmo_cnt_q  <= tmo_cnt_q + 20'd1;
          end
        end
        S_DATA: begin
          if (bus.rx_vld) begin
            wdata_q    <= {wdata_q[23:0], bus.rx_data};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            tmo_cnt_q  <= '0;
          end else begin
            tmo_cnt_q  <= tmo_cnt_q + 20'd1;
          end
        end
        S_ACC: begin
          if (is_write) begin
            rdata_q    <= {RSP_OK, 24'h0};
            resp_cnt_q <= 3'd1;
          end
        end
        S_RDWAIT: begin
          rdata_q    <= bus.ram_rdata;
          resp_cnt_q <= 3'd4;
        end
        S_RESP: begin
          if (tx_fire) begin
            rdata_q    <= {rdata_q[23:0], 8'h00};
            resp_cnt_q <= resp_cnt_q - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_bus_master.sv
// Bench for dbg_bus_master: packet vector table plus hand-written timeout,
// drop and mid-packet reset sequences, checked through an expected-value scoreboard.
module tb_dbg_bus_master;
  localparam int          TMO  = 100;
  localparam logic [31:0] JUNK = 32'hA5A5_5A5A;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;

  dbg_bus_if bus();

  dbg_bus_master #(.TIMEOUT(TMO)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gnt_delay;
    bit          exp_acc;
    bit          exp_wen;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_resp;
    int          exp_nresp;
  } vec_t;

  vec_t vecs[7];

  logic [64:0] exp_acc_q[$];
  logic [7:0]  exp_tx_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          gnt_delay = 0;
  int          req_cycles = 0;
  int          rd_stage = 0;
  int          tx_seen = 0;
  logic [31:0] cur_rdata = '0;
  logic        tx_prev = 1'b0;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // txrdy changes just after the active edge so sampled tx_vld matches what the DUT commits.
  always @(posedge clk) begin
    #1;
    bus.txrdy = ($urandom_range(0, 3) != 0);
  end

  // Monitor / responder: scoreboard pops, grant generator and read-data driver.
  always @(negedge clk) begin
    logic [64:0] e;
    if (rst) begin
      tx_prev       = 1'b0;
      req_cycles    = 0;
      rd_stage      = 0;
      bus.bus_gnt   = 1'b0;
      bus.ram_rdata = JUNK;
    end else begin
      if (rd_stage == 1) begin
        bus.ram_rdata = cur_rdata;
        rd_stage = 2;
      end else if (rd_stage == 2) begin
        bus.ram_rdata = JUNK;
        rd_stage = 0;
      end
      if (bus.ram_cen) begin
        if (exp_acc_q.size() == 0) begin
          check("unexpected_cen", 1, 0);
        end else begin
          e = exp_acc_q.pop_front();
          check("access", {bus.ram_wen, bus.ram_addr, bus.ram_wen ? bus.ram_wdata : 32'h0}, e);
          check("access_flag", bus.ram_flag, 4'hF);
          check("access_req", bus.bus_req, 1);
          check("grant_latency", req_cycles, gnt_delay + 1);
          if (!bus.ram_wen) rd_stage = 1;
        end
      end
      if (bus.tx_vld) begin
        check("tx_needs_txrdy", bus.txrdy, 1);
        check("tx_gap", tx_prev, 0);
        if (exp_tx_q.size() == 0) check("unexpected_tx", 1, 0);
        else check("tx_byte", bus.tx_data, exp_tx_q.pop_front());
        tx_seen++;
      end
      tx_prev = bus.tx_vld;
      if (bus.bus_req) begin
        if (req_cycles >= gnt_delay) bus.bus_gnt = 1'b1;
        req_cycles++;
      end else begin
        bus.bus_gnt = 1'b0;
        req_cycles  = 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_vld  = 1'b1;
    bus.rx_data = b;
    @(negedge clk);
    bus.rx_vld  = 1'b0;
    bus.rx_data = 8'($urandom_range(0, 255));
  endtask

  task automatic send_pkt(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] wdata);
    send_byte(cmd);
    if (cmd == 8'h57 || cmd == 8'h52)
      for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8]);
    if (cmd == 8'h57)
      for (int i = 3; i >= 0; i--) send_byte(wdata[8*i +: 8]);
  endtask

  task automatic push_exp(input vec_t v);
    if (v.exp_acc) exp_acc_q.push_back({v.exp_wen, v.exp_addr, v.exp_wen ? v.exp_wdata : 32'h0});
    for (int i = v.exp_nresp - 1; i >= 0; i--) exp_tx_q.push_back(v.exp_resp[8*i +: 8]);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (!bus.busy) break;
      @(negedge clk);
    end
    check(name, bus.busy, 0);
  endtask

  task automatic check_drained();
    check("acc_drained", exp_acc_q.size(), 0);
    check("tx_drained", exp_tx_q.size(), 0);
  endtask

  task automatic run_vec(input vec_t v);
    gnt_delay = v.gnt_delay;
    cur_rdata = v.rdata;
    push_exp(v);
    send_pkt(v.cmd, v.addr, v.wdata);
    wait_idle("idle_after_pkt");
    repeat (2) @(negedge clk);
    check_drained();
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_tx_vld"},    bus.tx_vld, 0);
    check({tag, "_tx_data"},   bus.tx_data, 8'h00);
    check({tag, "_bus_req"},   bus.bus_req, 0);
    check({tag, "_ram_cen"},   bus.ram_cen, 0);
    check({tag, "_ram_wen"},   bus.ram_wen, 0);
    check({tag, "_ram_addr"},  bus.ram_addr, 32'h0);
    check({tag, "_ram_flag"},  bus.ram_flag, 4'hF);
    check({tag, "_ram_wdata"}, bus.ram_wdata, 32'h0);
    check({tag, "_busy"},      bus.busy, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   base;
    //           cmd    addr          wdata         rdata         gd  acc   wen   exp_addr      exp_wdata     exp_resp      n
    vecs[0] = '{8'h57, 32'h40000107, 32'hDEADBEEF, 32'h0,        0,  1'b1, 1'b1, 32'h40000104, 32'hDEADBEEF, 32'h0000004B, 1};
    vecs[1] = '{8'h52, 32'h00000010, 32'h0,        32'h12345678, 0,  1'b1, 1'b0, 32'h00000010, 32'h0,        32'h12345678, 4};
    vecs[2] = '{8'h41, 32'h0,        32'h0,        32'h0,        0,  1'b0, 1'b0, 32'h0,        32'h0,        32'h0000003F, 1};
    vecs[3] = '{8'h57, 32'hFFFFFFFF, 32'h00000001, 32'h0,        3,  1'b1, 1'b1, 32'hFFFFFFFC, 32'h00000001, 32'h0000004B, 1};
    vecs[4] = '{8'h52, 32'h80000003, 32'h0,        32'hA500FF5A, 20, 1'b1, 1'b0, 32'h80000000, 32'h0,        32'hA500FF5A, 4};
    vecs[5] = '{8'h00, 32'h0,        32'h0,        32'h0,        0,  1'b0, 1'b0, 32'h0,        32'h0,        32'h0000003F, 1};
    vecs[6] = '{8'h57, 32'h00000000, 32'h12345678, 32'h0,        20, 1'b1, 1'b1, 32'h00000000, 32'h12345678, 32'h0000004B, 1};

    rst           = 1'b1;
    bus.rx_vld    = 1'b0;
    bus.rx_data   = 8'h00;
    bus.txrdy     = 1'b0;
    bus.bus_gnt   = 1'b0;
    bus.ram_rdata = JUNK;
    repeat (3) @(negedge clk);
    check_rst("in_rst");
    rst = 1'b0;
    @(negedge clk);
    check_rst("post_rst");

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Timeout: after the last accepted byte, 100 silent cycles return to IDLE.
    send_byte(8'h57);
    send_byte(8'h00);
    repeat (TMO - 1) @(negedge clk);
    check("tmo_not_early", bus.busy, 1);
    @(negedge clk);
    check("tmo_fired", bus.busy, 0);
    repeat (3) @(negedge clk);
    run_vec(vecs[1]);

    // A byte landing on the final timeout count is accepted.
    v = '{8'h52, 32'h0000003C, 32'h0, 32'h0BADF00D, 0, 1'b1, 1'b0, 32'h0000003C, 32'h0, 32'h0BADF00D, 4};
    gnt_delay = 0;
    cur_rdata = v.rdata;
    push_exp(v);
    send_byte(8'h52);
    send_byte(8'h00);
    repeat (TMO - 1) @(negedge clk);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h3C);
    wait_idle("idle_after_late_byte");
    repeat (2) @(negedge clk);
    check_drained();

    // Bytes arriving during the read response are dropped.
    v = '{8'h52, 32'h00000020, 32'h0, 32'hCAFEF00D, 2, 1'b1, 1'b0, 32'h00000020, 32'h0, 32'hCAFEF00D, 4};
    gnt_delay = v.gnt_delay;
    cur_rdata = v.rdata;
    push_exp(v);
    base = tx_seen;
    send_pkt(v.cmd, v.addr, v.wdata);
    for (int i = 0; i < 500; i++) begin
      if (tx_seen > base) break;
      @(negedge clk);
    end
    check("first_resp_byte_seen", tx_seen > base, 1);
    send_byte(8'h41);
    send_byte(8'h57);
    wait_idle("busy_after_final_tx");
    repeat (10) @(negedge clk);
    check("drop_stays_idle", bus.busy, 0);
    check_drained();

    // Reset in the middle of the data bytes aborts the packet.
    send_byte(8'h57);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(0, 255)));
    rst = 1'b1;
    @(negedge clk);
    check_rst("mid_rst");
    rst = 1'b0;
    @(negedge clk);
    check_rst("mid_post_rst");
    repeat (20) @(negedge clk);
    check("mid_rst_quiet", bus.busy, 0);
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dbg_bus_master.md
DBG_BUS_MASTER -- requirements
Module: dbg_bus_master

Interface
REQ-001 Parameter TIMEOUT, default 50000: inter-byte timeout in clk cycles; legal range 2 to 2^20-1.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 rx_vld  input  1  one-cycle strobe, rx_data valid.
REQ-005 rx_data  input  8  received UART byte.
REQ-006 txrdy  input  1  UART transmitter can accept a byte.
REQ-007 tx_vld  output  1  one-cycle strobe, tx_data valid.
REQ-008 tx_data  output  8  byte to transmit.
REQ-009 bus_req  output  1  request for the data bus.
REQ-010 bus_gnt  input  1  bus granted to this master.
REQ-011 ram_cen  output  1  bus access strobe.
REQ-012 ram_wen  output  1  1 = write, 0 = read; meaningful only with ram_cen.
REQ-013 ram_addr  output  32  word address; bits [1:0] always 0.
REQ-014 ram_flag  output  4  byte enables; always 4'hF.
REQ-015 ram_wdata  output  32  write data.
REQ-016 ram_rdata  input  32  read data, valid the cycle after the ram_cen cycle.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 Packet format: command byte, then 4 address bytes MSB first; write (0x57 'W') adds 4 data bytes MSB first; read is 0x52 'R'.
REQ-019 States: IDLE, ADDR, DATA, REQ, ACC, RDWAIT, RESP.
REQ-020 IDLE: rx 0x57 or 0x52 -> ADDR with the command latched; any other byte -> RESP with the single response byte 0x3F '?'.
REQ-021 ADDR: each rx byte shifts into the address register; after the 4th byte -> DATA for a write, -> REQ for a read.
REQ-022 DATA: each rx byte shifts into the wdata register; after the 4th byte -> REQ.
REQ-023 REQ: bus_req=1; enter ACC on the first cycle with bus_gnt=1. Wait is unbounded, with no timeout.
REQ-024 ACC: exactly one cycle with ram_cen=1, bus_req=1, ram_wen=(cmd==W), ram_addr={addr[31:2],2'b00}, ram_flag=4'hF.
REQ-025 After ACC, a write goes to RESP with the single response byte 0x4B 'K'; a read goes to RDWAIT.
REQ-026 RDWAIT: one cycle; capture ram_rdata, then -> RESP with 4 response bytes, MSB first.
REQ-027 RESP: drive tx_vld=1 for one cycle with the next byte whenever txrdy=1 and tx_vld was 0 on the previous cycle; after the last byte -> IDLE.
REQ-028 ram_cen, bus_req and tx_vld are 0 in all states other than those stated above.
REQ-029 rx bytes arriving in REQ, ACC, RDWAIT or RESP are dropped silently.
REQ-030 Timeout counter: cleared on each accepted rx byte and on entry to ADDR; counts only in ADDR and DATA.
REQ-031 Timeout: at count TIMEOUT-1 with no rx_vld -> IDLE, partial packet discarded, no response. rx_vld in that same cycle wins: the byte is accepted and there is no timeout.
REQ-032 A new packet may start in the cycle after the return to IDLE.

Reset
REQ-033 Asynchronous reset: state=IDLE; counters, command, address, wdata and rdata registers cleared.
REQ-034 Outputs held during and immediately after reset: tx_vld=0, tx_data=8'h00, bus_req=0, ram_cen=0, ram_wen=0, ram_addr=0, ram_flag=4'hF, ram_wdata=0, busy=0.
REQ-035 Reset asserted mid-packet or mid-access aborts with no bus strobe and no tx byte afterwards.

Verification
REQ-036 Write: rx 57 40 00 01 07 DE AD BE EF, bus_gnt=1 -> one ram_cen cycle with wen=1, addr=40000104, wdata=DEADBEEF, flag=F; then tx 4B.
REQ-037 Read: rx 52 00 00 00 10, ram_rdata=12345678 the cycle after ram_cen -> ram_cen with wen=0, addr=00000010; then tx 12 34 56 78 in order, each sent only while txrdy=1.
REQ-038 Grant stall: bus_gnt held 0 for 20 cycles -> bus_req=1 throughout and no ram_cen; ram_cen occurs in the cycle after bus_gnt rises.
REQ-039 Timeout: TIMEOUT=100; rx 57 00 then silence for 100 cycles -> IDLE, no bus access, no tx; a following full read packet executes correctly.
REQ-040 Bad command plus drop: rx 41 -> tx 3F; bytes sent during the RESP of a read are ignored; busy=0 after the final tx.
REQ-041 Reset during DATA: rx 57 + 6 bytes, assert rst -> all outputs take their reset values; a following write packet executes correctly.
